// File: rtl/gysc_reg_pkg.sv
// gysc_reg_pkg: address map, reset constants and shared types
// for the gyroscope readout register bank.
package gysc_reg_pkg;

    localparam logic [7:0] SAMPLE_BASE         = 8'h00;
    localparam logic [7:0] ADDR_WHO_AM_I       = 8'h20;
    localparam logic [7:0] ADDR_STATUS         = 8'h21;
    localparam logic [7:0] ADDR_MODE_CTRL      = 8'h22;
    localparam logic [7:0] ADDR_FIFO_WR_CTRL   = 8'h23;
    localparam logic [7:0] ADDR_FIFO_MODE_CTRL = 8'h24;
    localparam logic [7:0] ADDR_OFFSET_BASE    = 8'h28;

    localparam logic [31:0] FLOAT_QNAN       = 32'h7FC00000;
    localparam logic [7:0]  WHO_AM_I_DEFAULT = 8'h6B;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_SAMPLE,
        REG_WHO,
        REG_STATUS,
        REG_MODE,
        REG_FIFO_WR,
        REG_FIFO_MODE,
        REG_OFFSET
    } reg_sel_e;

    function automatic logic [7:0] byte_of(
        input logic [31:0] word,
        input logic [1:0]  sel
    );
        return word[8*sel +: 8];
    endfunction

endpackage

// File: rtl/gysc_reg_word.sv
// gysc_reg_word: one 32-bit sample word with a shadow copy that
// freezes the word on a byte-0 read so bytes 1-3 stay coherent.
module gysc_reg_word
    import gysc_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture_i,
    input  logic [31:0] cap_data_i,
    input  logic        snap_i,
    input  logic [1:0]  byte_sel_i,
    output logic [7:0]  rd_byte_o
);

    logic [31:0] live_q;
    logic [31:0] live_d;
    logic [31:0] shadow_q;
    logic [31:0] shadow_d;

    // Snapshot takes the pre-edge live value even when a capture
    // lands on the same edge.
    always_comb begin
        live_d   = capture_i ? cap_data_i : live_q;
        shadow_d = snap_i ? live_q : shadow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= FLOAT_QNAN;
            shadow_q <= FLOAT_QNAN;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
        end
    end

    assign rd_byte_o = (byte_sel_i == 2'd0) ? live_q[7:0]
                                            : byte_of(shadow_q, byte_sel_i);

endmodule

// File: rtl/gysc_reg_bank.sv
// gysc_reg_bank: byte-addressed host register bank holding float
// samples, identity, status and control for the gyro readout chain.
module gysc_reg_bank
    import gysc_reg_pkg::*;
#(
    parameter int         NUM_CH   = 3,
    parameter int         NUM_SRC  = 2,
    parameter logic [7:0] WHO_AM_I = WHO_AM_I_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*NUM_CH*32-1:0] src_data,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic                        host_req,
    input  logic                        host_we,
    input  logic [7:0]                  host_addr,
    input  logic [7:0]                  host_wdata,
    output logic                        host_rvalid,
    output logic [7:0]                  host_rdata,
    output logic                        host_err,
    output logic [7:0]                  mode_ctrl,
    output logic [7:0]                  fifo_wr_ctrl,
    output logic [7:0]                  fifo_mode_ctrl,
    output logic [NUM_CH*8-1:0]         offset
);

    localparam int NW = NUM_SRC * NUM_CH;

    logic [7:0]        samp_off;
    logic [7:0]        off_idx;
    reg_sel_e          sel;
    logic [NW-1:0]     snap;
    logic [7:0]        word_byte [NW];
    logic [7:0]        samp_byte;
    logic [7:0]        off_byte;

    logic              rvalid_q, rvalid_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [7:0]        mode_q, mode_d;
    logic [7:0]        fwr_q, fwr_d;
    logic [7:0]        fmode_q, fmode_d;
    logic [NUM_CH*8-1:0] offset_q, offset_d;
    logic [NUM_SRC-1:0]  status_q, status_d;
    logic              status_clr;

    assign samp_off = host_addr - SAMPLE_BASE;
    assign off_idx  = host_addr - ADDR_OFFSET_BASE;

    always_comb begin
        sel = REG_NONE;
        unique case (1'b1)
            (samp_off < 8'(NW*4)):                  sel = REG_SAMPLE;
            (host_addr == ADDR_WHO_AM_I):           sel = REG_WHO;
            (host_addr == ADDR_STATUS):             sel = REG_STATUS;
            (host_addr == ADDR_MODE_CTRL):          sel = REG_MODE;
            (host_addr == ADDR_FIFO_WR_CTRL):       sel = REG_FIFO_WR;
            (host_addr == ADDR_FIFO_MODE_CTRL):     sel = REG_FIFO_MODE;
            (off_idx < 8'(NUM_CH)):                 sel = REG_OFFSET;
            default:                                sel = REG_NONE;
        endcase
    end

    always_comb begin
        for (int w = 0; w < NW; w++) begin
            snap[w] = host_req && !host_we && (samp_off == 8'(w*4));
        end
    end

    always_comb begin
        samp_byte = 8'h00;
        for (int w = 0; w < NW; w++) begin
            if (samp_off[7:2] == 6'(w)) samp_byte = word_byte[w];
        end
    end

    always_comb begin
        off_byte = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            if (off_idx == 8'(c)) off_byte = offset_q[c*8 +: 8];
        end
    end

    genvar s, c;
    generate
        for (s = 0; s < NUM_SRC; s++) begin : g_src
            for (c = 0; c < NUM_CH; c++) begin : g_ch
                localparam int W = s*NUM_CH + c;
                gysc_reg_word u_word (
                    .clk        (clk),
                    .rst_n      (rst_n),
                    .capture_i  (src_valid[s]),
                    .cap_data_i (src_data[W*32 +: 32]),
                    .snap_i     (snap[W]),
                    .byte_sel_i (samp_off[1:0]),
                    .rd_byte_o  (word_byte[W])
                );
            end
        end
    endgenerate

    always_comb begin
        rvalid_d   = host_req;
        rdata_d    = 8'h00;
        err_d      = 1'b0;
        mode_d     = mode_q;
        fwr_d      = fwr_q;
        fmode_d    = fmode_q;
        offset_d   = offset_q;
        status_clr = 1'b0;
        if (host_req) begin
            unique case (sel)
                REG_SAMPLE: begin
                    if (host_we) err_d = 1'b1;
                    else rdata_d = samp_byte;
                end
                REG_WHO: begin
                    if (host_we) err_d = 1'b1;
                    else rdata_d = WHO_AM_I;
                end
                REG_STATUS: begin
                    if (host_we) err_d = 1'b1;
                    else begin
                        rdata_d    = 8'(status_q);
                        status_clr = 1'b1;
                    end
                end
                REG_MODE: begin
                    if (host_we) mode_d = host_wdata;
                    else rdata_d = mode_q;
                end
                REG_FIFO_WR: begin
                    if (host_we) fwr_d = host_wdata;
                    else rdata_d = fwr_q;
                end
                REG_FIFO_MODE: begin
                    if (host_we) fmode_d = host_wdata;
                    else rdata_d = fmode_q;
                end
                REG_OFFSET: begin
                    if (host_we) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (off_idx == 8'(k)) offset_d[k*8 +: 8] = host_wdata;
                        end
                    end else begin
                        rdata_d = off_byte;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
        // A new data-ready event beats a clear on the same edge.
        status_d = (status_clr ? '0 : status_q) | src_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 8'h00;
            err_q    <= 1'b0;
            mode_q   <= 8'h00;
            fwr_q    <= 8'h00;
            fmode_q  <= 8'h00;
            offset_q <= '0;
            status_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            mode_q   <= mode_d;
            fwr_q    <= fwr_d;
            fmode_q  <= fmode_d;
            offset_q <= offset_d;
            status_q <= status_d;
        end
    end

    assign host_rvalid    = rvalid_q;
    assign host_rdata     = rdata_q;
    assign host_err       = err_q;
    assign mode_ctrl      = mode_q;
    assign fifo_wr_ctrl   = fwr_q;
    assign fifo_mode_ctrl = fmode_q;
    assign offset         = offset_q;

endmodule

// File: tb/tb_gysc_reg_bank.sv
// tb_gysc_reg_bank: directed and randomized checks of the register
// bank against a byte-level behavioural model.
module tb_gysc_reg_bank;

    localparam int NUM_CH  = 3;
    localparam int NUM_SRC = 2;
    localparam int NW      = NUM_SRC * NUM_CH;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NW*32-1:0]     src_data;
    logic [NUM_SRC-1:0]   src_valid;
    logic                 host_req;
    logic                 host_we;
    logic [7:0]           host_addr;
    logic [7:0]           host_wdata;
    logic                 host_rvalid;
    logic [7:0]           host_rdata;
    logic                 host_err;
    logic [7:0]           mode_ctrl;
    logic [7:0]           fifo_wr_ctrl;
    logic [7:0]           fifo_mode_ctrl;
    logic [NUM_CH*8-1:0]  offset;

    always #5 clk = ~clk;

    gysc_reg_bank #(
        .NUM_CH   (NUM_CH),
        .NUM_SRC  (NUM_SRC),
        .WHO_AM_I (8'h6B)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rvalid    (host_rvalid),
        .host_rdata     (host_rdata),
        .host_err       (host_err),
        .mode_ctrl      (mode_ctrl),
        .fifo_wr_ctrl   (fifo_wr_ctrl),
        .fifo_mode_ctrl (fifo_mode_ctrl),
        .offset         (offset)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]        m_live   [NW];
    logic [31:0]        m_shadow [NW];
    logic [NUM_SRC-1:0] m_status;
    logic [7:0]         m_mode, m_fwr, m_fmode;
    logic [7:0]         m_off [NUM_CH];

    logic [7:0] exp_data;
    logic       exp_err;
    logic       got_valid;
    logic [7:0] got_data;
    logic       got_err;

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_live[w]   = 32'h7FC00000;
            m_shadow[w] = 32'h7FC00000;
        end
        m_status = '0;
        m_mode = 8'h00; m_fwr = 8'h00; m_fmode = 8'h00;
        for (int c = 0; c < NUM_CH; c++) m_off[c] = 8'h00;
    endtask

    function automatic logic [NUM_CH*8-1:0] model_offset();
        logic [NUM_CH*8-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c*8 +: 8] = m_off[c];
        return r;
    endfunction

    // Response computed from pre-edge state, then state advanced.
    task automatic model_step(input logic req, input logic we,
                              input logic [7:0] addr, input logic [7:0] wdata,
                              input logic [NUM_SRC-1:0] sv,
                              input logic [NW*32-1:0] sd);
        int a, w, b;
        logic clr;
        clr = 1'b0;
        exp_data = 8'h00;
        exp_err  = 1'b0;
        a = int'(addr);
        if (req) begin
            if (a < NW*4) begin
                w = a / 4;
                b = a % 4;
                if (we) exp_err = 1'b1;
                else if (b == 0) begin
                    exp_data = m_live[w][7:0];
                    m_shadow[w] = m_live[w];
                end else exp_data = 8'(m_shadow[w] >> (8*b));
            end else if (a == 'h20) begin
                if (we) exp_err = 1'b1; else exp_data = 8'h6B;
            end else if (a == 'h21) begin
                if (we) exp_err = 1'b1;
                else begin exp_data = 8'(m_status); clr = 1'b1; end
            end else if (a == 'h22) begin
                if (we) m_mode = wdata; else exp_data = m_mode;
            end else if (a == 'h23) begin
                if (we) m_fwr = wdata; else exp_data = m_fwr;
            end else if (a == 'h24) begin
                if (we) m_fmode = wdata; else exp_data = m_fmode;
            end else if (a >= 'h28 && a < 'h28 + NUM_CH) begin
                if (we) m_off[a-'h28] = wdata; else exp_data = m_off[a-'h28];
            end else exp_err = 1'b1;
        end
        if (clr) m_status = '0;
        m_status = m_status | sv;
        for (int s = 0; s < NUM_SRC; s++)
            if (sv[s])
                for (int c = 0; c < NUM_CH; c++)
                    m_live[s*NUM_CH+c] = sd[(s*NUM_CH+c)*32 +: 32];
    endtask

    function automatic logic [NW*32-1:0] rnd_sd();
        logic [NW*32-1:0] r;
        for (int w = 0; w < NW; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input logic req, input logic we,
                         input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [NUM_SRC-1:0] sv,
                         input logic [NW*32-1:0] sd);
        model_step(req, we, addr, wdata, sv, sd);
        host_req = req; host_we = we; host_addr = addr;
        host_wdata = wdata; src_valid = sv; src_data = sd;
        @(posedge clk);
        #1;
        got_valid = host_rvalid;
        got_data  = host_rdata;
        got_err   = host_err;
        host_req = 1'b0; host_we = 1'b0; src_valid = '0;
    endtask

    task automatic rd(input logic [7:0] addr);
        cycle(1'b1, 1'b0, addr, 8'h00, '0, src_data);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] d);
        cycle(1'b1, 1'b1, addr, d, '0, src_data);
    endtask

    task automatic test_reset();
        logic [7:0] addrs [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h20};
        logic [7:0] vals  [5] = '{8'h00, 8'h00, 8'hC0, 8'h7F, 8'h6B};
        rst_n = 1'b0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        src_valid = '0; src_data = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (host_rvalid !== 1'b0 || host_rdata !== 8'h00 || host_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp: got v=%b d=%h e=%b want 0 00 0",
                     host_rvalid, host_rdata, host_err);
        end
        n_checks++;
        if (mode_ctrl !== 8'h00 || fifo_wr_ctrl !== 8'h00 ||
            fifo_mode_ctrl !== 8'h00 || offset !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h %h %h %h want zeros",
                     mode_ctrl, fifo_wr_ctrl, fifo_mode_ctrl, offset);
        end
        for (int i = 0; i < 5; i++) begin
            rd(addrs[i]);
            n_checks++;
            if (got_valid !== 1'b1 || got_data !== vals[i] || got_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_read[%h]: got v=%b d=%h e=%b want 1 %h 0",
                         addrs[i], got_valid, got_data, got_err, vals[i]);
            end
        end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, '0, src_data);
        n_checks++;
        if (got_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_rvalid: got %b want 0", got_valid);
        end
    endtask

    task automatic test_coherence();
        logic [NW*32-1:0] sd;
        logic [7:0] seq_a [4] = '{8'h01, 8'h02, 8'h03, 8'h00};
        logic [7:0] seq_v [4] = '{8'h00, 8'h80, 8'h3F, 8'h00};
        sd = rnd_sd(); sd[31:0] = 32'h3F800000;
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 2'b01, sd);
        rd(8'h00);
        n_checks++;
        if (got_data !== 8'h00 || got_err !== 1'b0) begin
            n_fail++;
            $display("FAIL coh_b0: got %h e=%b want 00 0", got_data, got_err);
        end
        sd = rnd_sd(); sd[31:0] = 32'h40000000;
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 2'b01, sd);
        for (int i = 0; i < 4; i++) begin
            rd(seq_a[i]);
            n_checks++;
            if (got_data !== seq_v[i]) begin
                n_fail++;
                $display("FAIL coh_seq[%h]: got %h want %h",
                         seq_a[i], got_data, seq_v[i]);
            end
        end
        rd(8'h03);
        n_checks++;
        if (got_data !== 8'h40) begin
            n_fail++;
            $display("FAIL coh_resnap: got %h want 40", got_data);
        end
        sd = rnd_sd(); sd[31:0] = 32'h12345678;
        cycle(1'b1, 1'b0, 8'h00, 8'h00, 2'b01, sd);
        n_checks++;
        if (got_data !== 8'h00) begin
            n_fail++;
            $display("FAIL coh_same_edge_b0: got %h want 00", got_data);
        end
        rd(8'h03);
        n_checks++;
        if (got_data !== 8'h40) begin
            n_fail++;
            $display("FAIL coh_same_edge_b3: got %h want 40", got_data);
        end
        rd(8'h00);
        rd(8'h01);
        n_checks++;
        if (got_data !== 8'h56) begin
            n_fail++;
            $display("FAIL coh_new_b1: got %h want 56", got_data);
        end
    endtask

    task automatic test_status();
        rd(8'h21);
        n_checks++;
        if (got_data !== exp_data || got_err !== 1'b0) begin
            n_fail++;
            $display("FAIL status_drain: got %h want %h", got_data, exp_data);
        end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 2'b10, rnd_sd());
        rd(8'h21);
        n_checks++;
        if (got_data !== 8'h02) begin
            n_fail++;
            $display("FAIL status_set1: got %h want 02", got_data);
        end
        rd(8'h21);
        n_checks++;
        if (got_data !== 8'h00) begin
            n_fail++;
            $display("FAIL status_cleared: got %h want 00", got_data);
        end
        cycle(1'b1, 1'b0, 8'h21, 8'h00, 2'b01, rnd_sd());
        n_checks++;
        if (got_data !== 8'h00) begin
            n_fail++;
            $display("FAIL status_race_read: got %h want 00", got_data);
        end
        rd(8'h21);
        n_checks++;
        if (got_data !== 8'h01) begin
            n_fail++;
            $display("FAIL status_set_wins: got %h want 01", got_data);
        end
    endtask

    task automatic test_rw();
        wr(8'h22, 8'hA5);
        n_checks++;
        if (mode_ctrl !== 8'hA5 || got_err !== 1'b0 || got_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mode_write: got %h e=%b d=%h want A5 0 00",
                     mode_ctrl, got_err, got_data);
        end
        rd(8'h22);
        n_checks++;
        if (got_data !== 8'hA5 || got_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_read: got %h e=%b want A5 0", got_data, got_err);
        end
        wr(8'h23, 8'h5A);
        wr(8'h24, 8'hC3);
        wr(8'h2A, 8'h80);
        n_checks++;
        if (fifo_wr_ctrl !== 8'h5A || fifo_mode_ctrl !== 8'hC3 ||
            offset !== 24'h800000) begin
            n_fail++;
            $display("FAIL ctrl_regs: got %h %h %h want 5A C3 800000",
                     fifo_wr_ctrl, fifo_mode_ctrl, offset);
        end
        rd(8'h2A);
        n_checks++;
        if (got_data !== 8'h80) begin
            n_fail++;
            $display("FAIL offset_read: got %h want 80", got_data);
        end
    endtask

    task automatic test_errors();
        wr(8'h20, 8'hFF);
        n_checks++;
        if (got_err !== 1'b1 || got_data !== 8'h00) begin
            n_fail++;
            $display("FAIL wr_ro_err: got e=%b d=%h want 1 00", got_err, got_data);
        end
        rd(8'h20);
        n_checks++;
        if (got_data !== 8'h6B || got_err !== 1'b0) begin
            n_fail++;
            $display("FAIL who_after_wr: got %h want 6B", got_data);
        end
        rd(8'h3F);
        n_checks++;
        if (got_data !== 8'h00 || got_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_unmapped: got d=%h e=%b want 00 1", got_data, got_err);
        end
        wr(8'h2B, 8'h11);
        n_checks++;
        if (got_err !== 1'b1 || offset !== 24'h800000) begin
            n_fail++;
            $display("FAIL wr_off_oob: got e=%b off=%h want 1 800000", got_err, offset);
        end
        wr(8'h01, 8'h22);
        n_checks++;
        if (got_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_sample_err: got %b want 1", got_err);
        end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 2'b10, rnd_sd());
        wr(8'h21, 8'h00);
        n_checks++;
        if (got_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_status_err: got %b want 1", got_err);
        end
        rd(8'h21);
        n_checks++;
        if (got_data !== 8'h02) begin
            n_fail++;
            $display("FAIL status_kept: got %h want 02", got_data);
        end
    endtask

    task automatic test_random();
        logic req, we;
        logic [7:0] addr, wd;
        logic [NUM_SRC-1:0] sv;
        for (int i = 0; i < 400; i++) begin
            req  = ($urandom_range(0, 3) != 0);
            we   = ($urandom_range(0, 2) == 0);
            addr = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 'h2F));
            wd   = 8'($urandom);
            sv   = ($urandom_range(0, 3) == 0) ? NUM_SRC'($urandom) : '0;
            cycle(req, we, addr, wd, sv, rnd_sd());
            n_checks++;
            if (got_valid !== req || got_data !== exp_data || got_err !== exp_err) begin
                n_fail++;
                $display("FAIL rand[%0d] a=%h we=%b: got v=%b d=%h e=%b want %b %h %b",
                         i, addr, we, got_valid, got_data, got_err,
                         req, exp_data, exp_err);
            end
            n_checks++;
            if (mode_ctrl !== m_mode || fifo_wr_ctrl !== m_fwr ||
                fifo_mode_ctrl !== m_fmode || offset !== model_offset()) begin
                n_fail++;
                $display("FAIL rand_regs[%0d]: got %h %h %h %h want %h %h %h %h",
                         i, mode_ctrl, fifo_wr_ctrl, fifo_mode_ctrl, offset,
                         m_mode, m_fwr, m_fmode, model_offset());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] vals [4] = '{8'h00, 8'h00, 8'hC0, 8'h7F};
        wr(8'h28, 8'h7F);
        wr(8'h22, 8'h3C);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 2'b11, rnd_sd());
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (offset !== '0 || mode_ctrl !== 8'h00 || host_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got off=%h mode=%h v=%b want 0 00 0",
                     offset, mode_ctrl, host_rvalid);
        end
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h21;
        @(posedge clk);
        #1;
        n_checks++;
        if (host_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL req_in_reset: got rvalid %b want 0", host_rvalid);
        end
        host_req = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rd(8'h21);
        n_checks++;
        if (got_data !== 8'h00) begin
            n_fail++;
            $display("FAIL status_after_reset: got %h want 00", got_data);
        end
        for (int i = 0; i < 4; i++) begin
            rd(8'h14 + 8'(i));
            n_checks++;
            if (got_data !== vals[i] || got_err !== 1'b0) begin
                n_fail++;
                $display("FAIL nan_after_reset[%0d]: got %h want %h",
                         i, got_data, vals[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_coherence();
        test_status();
        test_rw();
        test_errors();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gysc_reg_bank.md
# gysc_reg_bank

Parametrised byte-addressed register bank for the gyroscope readout chain. It holds NUM_SRC × NUM_CH 32-bit float samples (filter and demodulator outputs per axis), identification, status and control registers. These are exposed to the host serial-interface slave over an 8-bit single-cycle request bus. It adds atomic multi-byte reads via per-word shadow latching, data-ready status, and error reporting.

## Interface
- NUM_CH, 3, number of axes (1–4)
- NUM_SRC, 2, sample sources per axis (1–2); constraint NUM_SRC*NUM_CH*4 ≤ 32
- WHO_AM_I, 8'h6B, value of the identity register
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- src_data  in  NUM_SRC*NUM_CH*32  sample words; word w=s*NUM_CH+c at [w*32 +: 32]
- src_valid  in  NUM_SRC  one-cycle strobe: capture all NUM_CH words of source s
- host_req  in  1  access request, single cycle
- host_we  in  1  1 = write, 0 = read
- host_addr  in  8  byte address
- host_wdata  in  8  write data
- host_rvalid  out  1  response strobe, one cycle after every host_req (reads and writes)
- host_rdata  out  8  read data, valid with host_rvalid, 8'h00 otherwise
- host_err  out  1  with host_rvalid: unmapped address or write to read-only
- mode_ctrl  out  8  MODE_CTRL register contents
- fifo_wr_ctrl  out  8  FIFO_WR_CTRL contents
- fifo_mode_ctrl  out  8  FIFO_MODE_CTRL contents
- offset  out  NUM_CH*8  per-axis signed offset, axis c at [c*8 +: 8]

## Operation
- Address map:
  - 0x00 + 4*w + b: sample word w, byte b (b=0 LSB), RO.
  - 0x20 WHO_AM_I, RO.
  - 0x21 STATUS, RO, clear-on-read; bit s = source s data-ready.
  - 0x22 MODE_CTRL, RW. 0x23 FIFO_WR_CTRL, RW. 0x24 FIFO_MODE_CTRL, RW.
  - 0x28 + c OFFSET[c], RW, for c < NUM_CH.
  - Everything else is unmapped.
- Live words: on src_valid[s], live words of source s ← src_data slices.
- Coherent reads:
  - A read of byte 0 of word w returns live[w][7:0] and copies live[w] into shadow[w].
  - Reads of bytes 1–3 return shadow[w].
  - A host reading b0→b3 therefore gets one sample, even if src_valid fires mid-sequence.
- STATUS: bit s set by src_valid[s], cleared by a STATUS read. If a set and the clear hit the same edge, the set wins; the read returns the pre-edge value.
- Writes to RW registers take effect at the request edge; outputs update the same edge.
- Writes to RO or unmapped addresses: no state change, host_err=1, host_rdata=0.
- Reads of unmapped addresses: host_rdata=0, host_err=1.
- Bits [7:NUM_SRC] of STATUS read as 0.

## Timing
- Reset values:
  - live and shadow words = 32'h7FC00000 (quiet NaN).
  - STATUS = 0; all RW registers = 8'h00.
  - host_rvalid = 0, host_rdata = 0, host_err = 0.
- Read latency is 1 cycle: host_req at edge N gives host_rvalid/host_rdata/host_err registered at edge N+1.
- Back-to-back requests are allowed every cycle; there is no backpressure.
- If src_valid and a byte-0 read of the same word hit the same edge, the read data and shadow take the old live value; live takes the new value.
- Reset mid-sequence aborts the access. No host_rvalid is issued for a request sampled during reset.

## Structure
- Shared package gysc_reg_pkg holds:
  - address constants: SAMPLE_BASE, ADDR_WHO_AM_I, ADDR_STATUS, ADDR_MODE_CTRL, ADDR_FIFO_WR_CTRL, ADDR_FIFO_MODE_CTRL, ADDR_OFFSET_BASE
  - FLOAT_QNAN = 32'h7FC00000
  - the default WHO_AM_I value
- Sub-module gysc_reg_word: one 32-bit live word plus shadow, with capture/snapshot inputs and a byte-select read port. It is instantiated NUM_SRC*NUM_CH times.

## Test plan
- Reset, then read 0x00–0x03 and 0x20 → 00,00,C0,7F,6B; host_err=0 on every response; rvalid one cycle after each req.
- Coherence:
  1. src_valid[0] with word0=32'h3F800000; read byte 0.
  2. Pulse src_valid[0] with 32'h40000000; read bytes 1–3.
  3. → 00,00,80,3F.
  4. Re-read byte 0 → 00, snapshotting 40000000; then byte 3 → 40.
- STATUS:
  1. src_valid[1] pulse; read 0x21 → 02; read again → 00.
  2. src_valid[0] on the same edge as a STATUS read → read returns 00, next read → 01.
- Write 0xA5 to 0x22 → mode_ctrl=A5 after that edge; read 0x22 → A5, host_err=0.
- Error handling:
  - Write to 0x20 → host_err=1, re-read 0x20 → 6B.
  - Read 0x3F → rdata 00, host_err=1.
  - Write 0x2B with NUM_CH=3 → host_err=1.
- Reset mid-operation: write 0x28=0x7F, assert rst_n low asynchronously between edges → offset, mode_ctrl and STATUS are 0 immediately, and samples read 7FC00000 after release.
